ballot_controller: RTL and testbench
====================================

# ballot_controller

Sequences one voting session at a time for the 4-candidate voting machine. Once an officer arms a ballot, it accepts exactly one validated button press, then increments that candidate's saturating 8-bit tally and pulses `casted_vote`. The tallies and `casted_vote` feed the existing result/display block. The controller rejects multi-button presses, short presses, votes while in result mode, and abandoned ballots (timeout).

## Interface
- `HOLD_CYCLES`, default 4: consecutive cycles a single button must be held to count; legal range ≥2.
- `TIMEOUT`, default 1000: cycles an armed ballot may wait before being abandoned; legal range > `HOLD_CYCLES`.
- `clock` input 1: single clock; all logic is posedge.
- `reset` input 1: synchronous, active-high; highest priority.
- `mode` input 1: 0 = voting, 1 = result display. Voting is disabled while it is 1.
- `ballot_enable` input 1: officer arm request; sampled in IDLE only.
- `candi1_press` … `candi4_press` input 1 each: raw candidate buttons, already synchronised to `clock`.
- `candi1_votes` … `candi4_votes` output 8 each: registered tallies.
- `casted_vote` output 1: one-cycle pulse when a vote is committed.
- `armed` output 1: high in ARMED, HOLD and COMMIT (ballot lamp).
- `timed_out` output 1: one-cycle pulse when an armed ballot expires.
- `overflow` output 1: sticky flag; set when any tally is already 255 at commit.

## Operation
- A press is valid when exactly one of the four press inputs is high (one-hot). Zero buttons, or two or more, count as no valid press.
- States: IDLE, ARMED, HOLD, COMMIT, RELEASE.
- **IDLE**:
  - `mode`=0 and `ballot_enable`=1 → ARMED; timeout counter cleared.
  - Otherwise stay in IDLE.
- **ARMED**:
  - Valid press → HOLD. Latch the one-hot candidate; hold counter = 1.
- **HOLD**:
  - Same one-hot still present → hold counter +1. When the count would reach `HOLD_CYCLES` → COMMIT.
  - Any change (release, different button, extra button) → ARMED. The hold counter is discarded.
- **COMMIT** (one cycle):
  - Latched candidate's tally +1, saturating at 255.
  - If that tally was already 255 → tally unchanged, `overflow` set.
  - → RELEASE.
- **RELEASE**: wait until all four press inputs are 0 → IDLE. This prevents a held button from voting again on the next ballot.
- **Timeout counter**:
  - Runs in ARMED and HOLD; not restarted by HOLD aborts.
  - Reaching `TIMEOUT` → IDLE with a `timed_out` pulse, no vote.
- **Priority per cycle**: reset > `mode`=1 abort > HOLD completion > timeout.
  - `mode`=1 in ARMED or HOLD → IDLE with no vote and no `timed_out`.
  - `mode` changing during COMMIT/RELEASE does not cancel the commit.
- `ballot_enable` is ignored outside IDLE, so repeated arming cannot stack ballots.
- Tallies change only in COMMIT and on reset. `mode` never clears them.

## Timing
- **Reset** (synchronous): state IDLE; all tallies 0x00; `casted_vote`, `armed`, `timed_out`, `overflow` all 0; internal counters 0.
- **Arming**: `ballot_enable` sampled high at posedge t in IDLE → `armed`=1 from t+1.
- **Vote latency**: first sample of a valid one-hot at posedge p (state ARMED) → samples at p … p+HOLD_CYCLES−1.
  - State = COMMIT after posedge p+HOLD_CYCLES−1.
  - Updated tally and `casted_vote`=1 visible after posedge p+HOLD_CYCLES, for exactly one cycle.
  - `armed` drops at that same edge.
- **Timeout**: `timed_out` is high for the one cycle following the edge at which the counter reaches `TIMEOUT`; `armed` is 0 in that cycle.
- **Reset mid-operation**: reset in any state returns everything to reset values at the next edge; a pending commit is lost.
- **Outputs**: all are registered; no combinational path from inputs to outputs.

## Test plan
- **Basic vote**: reset, `mode`=0, pulse `ballot_enable`, hold `candi2_press` for 4 cycles → `candi2_votes`=0x01, one `casted_vote` pulse 4 edges after first sample; other tallies stay 0x00.
- **Short and multi press**:
  - armed, `candi1_press` for 3 cycles then release → no vote, still armed.
  - then `candi1`+`candi3` together for 10 cycles → no vote.
  - then `candi3` alone for 4 cycles → `candi3_votes`=0x01.
- **Held button across ballots**: after a commit, keep `candi4_press` high and pulse `ballot_enable` → stays in RELEASE, no second vote until release; after release and re-arm, 4-cycle hold → `candi4_votes`=0x02.
- **Timeout and mode abort**:
  - `TIMEOUT`=20: arm with no press → `timed_out` pulse 20 cycles later, no tally change.
  - arm, raise `mode` mid-HOLD → IDLE, no vote, no `timed_out`.
  - `ballot_enable` with `mode`=1 → `armed` stays 0.
- **Saturation**: 256 valid votes for candidate 1 → `candi1_votes`=0xFF, `overflow`=1 after the 256th commit, `casted_vote` still pulses.
- **Reset during HOLD**: assert reset mid-hold → all outputs 0 at the next edge, no vote counted.

Source files
------------

// File: rtl/ballot_controller.sv
// ballot_controller
// Runs one voting session at a time for a 4-candidate machine. An officer arms
// a ballot. The machine then accepts exactly one validated press: a single
// button held for HOLD_CYCLES consecutive cycles. It then bumps that
// candidate's saturating 8-bit tally and pulses casted_vote.
//
// Ports
//   clock, reset            : posedge clock, synchronous active-high reset
//   mode                    : 0 = voting, 1 = result display (aborts ballots)
//   ballot_enable           : officer arm request, looked at in IDLE only
//   candi1..4_press         : raw candidate buttons, already synchronised
//   candi1..4_votes [7:0]   : registered tallies
//   casted_vote             : 1-cycle pulse per committed vote
//   armed                   : ballot lamp (ARMED / HOLD / COMMIT)
//   timed_out               : 1-cycle pulse when an armed ballot expires
//   overflow                : sticky, a commit hit a tally already at 255
module ballot_controller #(
  parameter int HOLD_CYCLES = 4,
  parameter int TIMEOUT     = 1000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       mode,
  input  logic       ballot_enable,
  input  logic       candi1_press,
  input  logic       candi2_press,
  input  logic       candi3_press,
  input  logic       candi4_press,
  output logic [7:0] candi1_votes,
  output logic [7:0] candi2_votes,
  output logic [7:0] candi3_votes,
  output logic [7:0] candi4_votes,
  output logic       casted_vote,
  output logic       armed,
  output logic       timed_out,
  output logic       overflow
);
  localparam int NUM_CAND = 4;
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [HW-1:0] HC_V = HW'(HOLD_CYCLES);
  localparam logic [TW-1:0] TO_V = TW'(TIMEOUT);

  typedef enum logic [2:0] {S_IDLE, S_ARMED, S_HOLD, S_COMMIT, S_RELEASE} state_t;

  state_t                           r_state;
  logic [NUM_CAND-1:0]              r_cand;
  logic [HW-1:0]                    r_hcnt;
  logic [TW-1:0]                    r_tcnt;
  logic [NUM_CAND-1:0][7:0]         r_votes;

  logic [NUM_CAND-1:0] w_press;
  logic                w_onehot;
  logic                w_any;
  logic                w_same;
  logic [HW-1:0]       w_hcnt_nx;
  logic [TW-1:0]       w_tcnt_nx;
  logic                w_hold_done;
  logic                w_to_hit;

  assign w_press     = {candi4_press, candi3_press, candi2_press, candi1_press};
  assign w_any       = |w_press;
  // x & (x-1) clears the lowest set bit; zero result means at most one bit set
  assign w_onehot    = w_any && ((w_press & (w_press - 4'd1)) == 4'd0);
  assign w_same      = (w_press == r_cand);
  assign w_hcnt_nx   = r_hcnt + HW'(1);
  assign w_tcnt_nx   = r_tcnt + TW'(1);
  assign w_hold_done = (w_hcnt_nx == HC_V);
  assign w_to_hit    = (w_tcnt_nx == TO_V);

  assign candi1_votes = r_votes[0];
  assign candi2_votes = r_votes[1];
  assign candi3_votes = r_votes[2];
  assign candi4_votes = r_votes[3];

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cand      <= '0;
      r_hcnt      <= '0;
      r_tcnt      <= '0;
      r_votes     <= '0;
      casted_vote <= 1'b0;
      armed       <= 1'b0;
      timed_out   <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      casted_vote <= 1'b0;
      timed_out   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!mode && ballot_enable) begin
            r_state <= S_ARMED;
            armed   <= 1'b1;
            r_tcnt  <= '0;
          end
        end
        S_ARMED: begin
          if (mode) begin
            r_state <= S_IDLE;
            armed   <= 1'b0;
          end else if (w_to_hit) begin
            r_state   <= S_IDLE;
            armed     <= 1'b0;
            timed_out <= 1'b1;
          end else begin
            r_tcnt <= w_tcnt_nx;
            if (w_onehot) begin
              r_state <= S_HOLD;
              r_cand  <= w_press;
              r_hcnt  <= HW'(1);
            end
          end
        end
        S_HOLD: begin
          // hold completion outranks timeout on the same edge
          if (mode) begin
            r_state <= S_IDLE;
            armed   <= 1'b0;
          end else if (w_same && w_hold_done) begin
            r_state <= S_COMMIT;
          end else if (w_to_hit) begin
            r_state   <= S_IDLE;
            armed     <= 1'b0;
            timed_out <= 1'b1;
          end else begin
            r_tcnt <= w_tcnt_nx;
            if (w_same) begin
              r_hcnt <= w_hcnt_nx;
            end else begin
              r_state <= S_ARMED;
              r_hcnt  <= '0;
            end
          end
        end
        S_COMMIT: begin
          for (int i = 0; i < NUM_CAND; i++) begin
            if (r_cand[i]) begin
              if (r_votes[i] == 8'hFF) overflow <= 1'b1;
              else                     r_votes[i] <= r_votes[i] + 8'd1;
            end
          end
          casted_vote <= 1'b1;
          armed       <= 1'b0;
          r_hcnt      <= '0;
          r_state     <= S_RELEASE;
        end
        S_RELEASE: begin
          // a button still held from this ballot must not vote on the next one
          if (!w_any) r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          armed   <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ballot_controller.sv
module tb_ballot_controller;
  localparam int H  = 4;
  localparam int TO = 20;

  logic       clock = 1'b0;
  logic       reset, mode, ballot_enable;
  logic [3:0] press;
  logic [7:0] v1, v2, v3, v4;
  logic       cv, arm, tmo, ovf;

  ballot_controller #(.HOLD_CYCLES(H), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .mode(mode), .ballot_enable(ballot_enable),
    .candi1_press(press[0]), .candi2_press(press[1]),
    .candi3_press(press[2]), .candi4_press(press[3]),
    .candi1_votes(v1), .candi2_votes(v2), .candi3_votes(v3), .candi4_votes(v4),
    .casted_vote(cv), .armed(arm), .timed_out(tmo), .overflow(ovf)
  );

  always #5 clock = ~clock;

  int n_tests = 0, n_fail = 0;
  int exp_v[4];
  int exp_ovf = 0;
  int n_cast = 0, n_to = 0, exp_cast = 0, exp_to = 0;

  // pulse counters catch any extra or missing casted_vote / timed_out pulse
  always @(negedge clock) begin
    if (cv)  n_cast++;
    if (tmo) n_to++;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int tally(input int c);
    case (c)
      0: return int'(v1);
      1: return int'(v2);
      2: return int'(v3);
      default: return int'(v4);
    endcase
  endfunction

  task automatic cyc();
    @(posedge clock); #1;
  endtask

  task automatic chk_tallies(input string tag);
    for (int i = 0; i < 4; i++) chk($sformatf("%s_v%0d", tag, i + 1), tally(i), exp_v[i]);
    chk({tag, "_ovf"}, int'(ovf), exp_ovf);
  endtask

  task automatic chk_pulses(input string tag);
    chk({tag, "_ncast"}, n_cast, exp_cast);
    chk({tag, "_nto"}, n_to, exp_to);
  endtask

  task automatic do_reset();
    reset = 1'b1; cyc(); reset = 1'b0;
    for (int i = 0; i < 4; i++) exp_v[i] = 0;
    exp_ovf = 0;
    chk_tallies("rst");
    chk("rst_cv", int'(cv), 0);
    chk("rst_arm", int'(arm), 0);
    chk("rst_tmo", int'(tmo), 0);
  endtask

  task automatic do_arm();
    ballot_enable = 1'b1; cyc(); ballot_enable = 1'b0;
    chk("arm", int'(arm), 1);
  endtask

  // from ARMED: hold candidate c; expects commit after exactly H samples
  task automatic hold_commit(input int c, input bit full);
    press = 4'(1 << c);
    repeat (H) cyc();
    if (full) begin
      chk("pre_commit_arm", int'(arm), 1);
      chk("pre_commit_cv", int'(cv), 0);
    end
    cyc();
    if (exp_v[c] == 255) exp_ovf = 1;
    else exp_v[c]++;
    exp_cast++;
    chk("commit_cv", int'(cv), 1);
    chk("commit_arm", int'(arm), 0);
    if (full) chk_tallies("commit");
    else chk($sformatf("commit_v%0d", c + 1), tally(c), exp_v[c]);
    cyc();
    chk("post_commit_cv", int'(cv), 0);
  endtask

  task automatic release_btn();
    press = 4'b0; cyc();
  endtask

  task automatic vote(input int c, input bit full);
    do_arm(); hold_commit(c, full); release_btn();
  endtask

  function automatic logic [3:0] multi_mask();
    logic [3:0] m;
    do m = 4'($urandom_range(0, 15)); while ($countones(m) < 2);
    return m;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
    $fatal(1);
  end

  initial begin
    int c, k, sc;
    reset = 1'b0; mode = 1'b0; ballot_enable = 1'b0; press = 4'b0;
    cyc();
    do_reset();

    // basic vote on candidate 2
    vote(1, 1'b1);
    chk_pulses("basic");

    for (int it = 0; it < 60; it++) begin
      sc = $urandom_range(0, 6);
      c  = $urandom_range(0, 3);
      case (sc)
        0: vote(c, 1'b1);
        1: begin // short press then release, then a real vote
          do_arm();
          k = $urandom_range(1, H - 1);
          press = 4'(1 << c); repeat (k) cyc();
          press = 4'b0; cyc();
          chk("short_arm", int'(arm), 1);
          chk_pulses("short");
          hold_commit(c, 1'b1); release_btn();
        end
        2: begin // multi-button press never counts
          do_arm();
          press = multi_mask();
          k = $urandom_range(1, 8);
          repeat (k) cyc();
          chk("multi_arm", int'(arm), 1);
          chk_pulses("multi");
          hold_commit(c, 1'b1); release_btn();
        end
        3: begin // abandoned ballot, possibly with invalid presses
          do_arm();
          press = ($urandom_range(0, 1) == 1) ? multi_mask() : 4'b0;
          repeat (TO - 1) cyc();
          chk("to_pre_arm", int'(arm), 1);
          chk("to_pre_tmo", int'(tmo), 0);
          cyc();
          exp_to++;
          chk("to_tmo", int'(tmo), 1);
          chk("to_arm", int'(arm), 0);
          cyc();
          chk("to_post_tmo", int'(tmo), 0);
          press = 4'b0; cyc();
          chk_tallies("to");
        end
        4: begin // mode abort mid-hold, including the edge hold would finish
          do_arm();
          k = $urandom_range(1, H - 1);
          press = 4'(1 << c); repeat (k) cyc();
          mode = 1'b1; cyc();
          chk("mode_abort_arm", int'(arm), 0);
          mode = 1'b0; press = 4'b0; cyc();
          chk("mode_idle_arm", int'(arm), 0);
          cyc();
          chk_tallies("mode_abort");
        end
        5: begin // arming blocked in result mode
          mode = 1'b1; ballot_enable = 1'b1;
          repeat (3) cyc();
          chk("mode1_arm", int'(arm), 0);
          ballot_enable = 1'b0; cyc();
          mode = 1'b0; cyc();
          chk("mode1_arm_after", int'(arm), 0);
        end
        default: begin // held button across ballots
          do_arm(); hold_commit(c, 1'b1);
          ballot_enable = 1'b1; repeat (4) cyc();
          chk("held_arm", int'(arm), 0);
          ballot_enable = 1'b0; cyc();
          chk("held_arm2", int'(arm), 0);
          release_btn();
          vote(c, 1'b1);
        end
      endcase
      chk_pulses($sformatf("it%0d", it));
    end

    // saturation on candidate 1
    do_reset();
    repeat (255) vote(0, 1'b0);
    chk("sat255_v1", int'(v1), 255);
    chk("sat255_ovf", int'(ovf), 0);
    vote(0, 1'b1);
    chk("sat256_v1", int'(v1), 255);
    chk("sat256_ovf", int'(ovf), 1);
    chk_pulses("sat");

    // reset during hold loses the pending vote
    vote(2, 1'b1);
    do_arm();
    press = 4'b0010; repeat (2) cyc();
    reset = 1'b1; cyc();
    for (int i = 0; i < 4; i++) chk($sformatf("midrst_v%0d", i + 1), tally(i), 0);
    chk("midrst_arm", int'(arm), 0);
    chk("midrst_cv", int'(cv), 0);
    chk("midrst_ovf", int'(ovf), 0);
    chk("midrst_tmo", int'(tmo), 0);
    reset = 1'b0; repeat (H + 2) cyc();
    press = 4'b0; cyc();
    chk("midrst_v2_after", int'(v2), 0);
    chk_pulses("midrst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
